// File: rtl/pipe_generator.sv
// pipe_generator: scrolling pipe obstacles for the FlappyBird game.
//
// Keeps NUM_PIPES pipe slots. Each slot holds its right-edge x and its gap-top y.
// The block only changes state on a frame tick while running:
//   - Every occupied slot scrolls left by the effective speed.
//   - A slot that would scroll off the screen is retired instead.
//   - A distance counter decides when a new pipe is spawned into the
//     lowest-index free slot. The new gap height comes from rand_num.
//
// Ports:
//   clk, rstn     clock; asynchronous active-low reset
//   frame_tick    one-cycle pulse per frame
//   run           game running (low pauses)
//   clear         synchronous return to IDLE with all slots emptied
//   rand_num      random word (only bits [15:0] are used)
//   pipe_valid    per-slot occupied flag
//   pipe_x        per-slot right-edge x, slot i at [i*X_W +: X_W]
//   pipe_gap_y    per-slot gap-top y, slot i at [i*Y_W +: Y_W]
//   score_pulse   one-cycle pulse when any pipe crosses BIRD_X
//   busy          high whenever the FSM is not in IDLE
//   state_dbg     current FSM state (0 IDLE, 1 RUN, 2 PAUSE)
//
// Optional feature: define PIPE_SPEEDUP_EN to make the scroll speed rise by 1
// after every 8 score pulses, capped at 2*SPEED.
//
// Handshake: there is no valid/ready flow control. Inputs are sampled on every
// clock edge. Outputs are registers that update one cycle after a frame tick
// is taken in RUN, and are held at all other times.
module pipe_generator #(
  parameter int SCREEN_W  = 640,
  parameter int PIPE_W    = 52,
  parameter int SPEED     = 2,
  parameter int SPACING   = 240,
  parameter int GAP_MIN   = 40,
  parameter int GAP_RANGE = 200,
  parameter int BIRD_X    = 160,
  parameter int NUM_PIPES = 4,
  parameter int X_W       = 11,
  parameter int Y_W       = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     frame_tick,
  input  logic                     run,
  input  logic                     clear,
  input  logic [31:0]              rand_num,
  output logic [NUM_PIPES-1:0]     pipe_valid,
  output logic [NUM_PIPES*X_W-1:0] pipe_x,
  output logic [NUM_PIPES*Y_W-1:0] pipe_gap_y,
  output logic                     score_pulse,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  // The counter width covers SPACING plus one maximum speed step.
  localparam int CNT_W = $clog2(SPACING + 2*SPEED + 1);
  localparam logic [X_W-1:0]   SPAWN_X  = X_W'(SCREEN_W + PIPE_W);
  localparam logic [X_W-1:0]   BIRD     = X_W'(BIRD_X);
  localparam logic [X_W-1:0]   SPD_BASE = X_W'(SPEED);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SPACING);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [X_W-1:0]           spd;

  logic                     tick_en;
  logic [NUM_PIPES-1:0]     nx_valid;
  logic [NUM_PIPES*X_W-1:0] nx_x;
  logic [NUM_PIPES*Y_W-1:0] nx_gap;
  logic                     hit;
  logic [NUM_PIPES-1:0]     free_oh;
  logic [CNT_W-1:0]         cnt_sum;
  logic [CNT_W-1:0]         cnt_sat;
  logic                     do_spawn;
  logic [31:0]              prod;
  logic [Y_W-1:0]           spawn_gap;
  logic                     unused_bits;

  assign tick_en   = (state == RUN) && frame_tick;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Isolate the lowest free slot as a one-hot mask. Occupancy is taken before
  // the tick, so a slot retired on this tick cannot be refilled until the next one.
  assign free_oh  = ~pipe_valid & (pipe_valid + NUM_PIPES'(1));

  // Advance the distance counter, saturating at SPACING. While every slot is
  // full, the counter therefore waits at SPACING for a free slot.
  assign cnt_sum  = cnt + CNT_W'(spd);
  assign cnt_sat  = (cnt_sum >= CNT_FULL) ? CNT_FULL : cnt_sum;
  assign do_spawn = (cnt_sat == CNT_FULL) && (|free_oh);

  // Scale the 16-bit random value into [0, GAP_RANGE) using the upper half of
  // the product.
  assign prod        = 32'(rand_num[15:0]) * 32'(GAP_RANGE);
  assign spawn_gap   = Y_W'(GAP_MIN) + Y_W'(prod[31:16]);
  assign unused_bits = ^{rand_num[31:16], prod[15:0]};

  always_comb begin
    nx_valid = pipe_valid;
    nx_x     = pipe_x;
    nx_gap   = pipe_gap_y;
    hit      = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (pipe_valid[i]) begin
        if (pipe_x[i*X_W +: X_W] <= spd) begin
          nx_valid[i] = 1'b0;
        end else begin
          nx_x[i*X_W +: X_W] = pipe_x[i*X_W +: X_W] - spd;
          if (pipe_x[i*X_W +: X_W] > BIRD && nx_x[i*X_W +: X_W] <= BIRD)
            hit = 1'b1;
        end
      end
      // The spawn target was free before the tick, so a new pipe is never
      // moved on its spawn tick.
      if (do_spawn && free_oh[i]) begin
        nx_valid[i]          = 1'b1;
        nx_x[i*X_W +: X_W]   = SPAWN_X;
        nx_gap[i*Y_W +: Y_W] = spawn_gap;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pipe_valid  <= '0;
      pipe_x      <= '0;
      pipe_gap_y  <= '0;
      score_pulse <= 1'b0;
      cnt         <= CNT_FULL;
    end else if (clear) begin
      state       <= IDLE;
      pipe_valid  <= '0;
      pipe_x      <= '0;
      pipe_gap_y  <= '0;
      score_pulse <= 1'b0;
      cnt         <= CNT_FULL;
    end else begin
      score_pulse <= 1'b0;
      if (tick_en) begin
        pipe_valid  <= nx_valid;
        pipe_x      <= nx_x;
        pipe_gap_y  <= nx_gap;
        score_pulse <= hit;
        cnt         <= do_spawn ? '0 : cnt_sat;
      end
      case (state)
        IDLE:    if (run)  state <= RUN;
        RUN:     if (!run) state <= PAUSE;
        PAUSE:   if (run)  state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_SPEEDUP_EN
  localparam logic [X_W-1:0] SPD_MAX = X_W'(2*SPEED);
  logic [2:0] pulse_cnt;

  // The new speed takes effect on the tick after the eighth crossing. It
  // drives both the scroll step and the distance counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spd       <= SPD_BASE;
      pulse_cnt <= '0;
    end else if (clear) begin
      spd       <= SPD_BASE;
      pulse_cnt <= '0;
    end else if (tick_en && hit) begin
      pulse_cnt <= pulse_cnt + 3'd1;
      if (pulse_cnt == 3'd7 && spd < SPD_MAX)
        spd <= spd + X_W'(1);
    end
  end
`else
  assign spd = SPD_BASE;
`endif

endmodule

// File: tb/tb_pipe_generator.sv
// Testbench for pipe_generator, instantiated with two pipe slots so that the
// all-slots-full deferral can be reached.
//
// Checking works as follows:
//   - A driver applies inputs at each falling edge.
//   - A reference model steps on the same inputs and pushes the expected
//     post-edge outputs into exp_q.
//   - A monitor pops one entry after each rising edge and compares it with the DUT.
//   - Directed spot checks anchor the known timeline: spawn, spacing, score,
//     retirement and deferral.
module tb_pipe_generator;
  localparam int NP        = 2;
  localparam int XW        = 11;
  localparam int YW        = 10;
  localparam int SPEED     = 2;
  localparam int SPACING   = 240;
  localparam int BIRD_X    = 160;
  localparam int SPAWN_X   = 692;
  localparam int GAP_MIN   = 40;
  localparam int GAP_RANGE = 200;
  localparam int W         = 4 + NP + NP*XW + NP*YW;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            frame_tick = 1'b0;
  logic            run = 1'b0;
  logic            clear = 1'b0;
  logic [31:0]     rand_num = '0;
  logic [NP-1:0]   pipe_valid;
  logic [NP*XW-1:0] pipe_x;
  logic [NP*YW-1:0] pipe_gap_y;
  logic            score_pulse;
  logic            busy;
  logic [1:0]      state_dbg;

  pipe_generator #(.NUM_PIPES(NP)) dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .run(run), .clear(clear),
    .rand_num(rand_num), .pipe_valid(pipe_valid), .pipe_x(pipe_x),
    .pipe_gap_y(pipe_gap_y), .score_pulse(score_pulse), .busy(busy),
    .state_dbg(state_dbg)
  );

  // Clock and reset. Reset starts asserted and is released by the driver.
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: game state described with plain integers.
  int m_state;        // 0 idle, 1 run, 2 pause
  bit m_v[NP];
  int m_x[NP];
  int m_g[NP];
  int m_cnt;
  bit m_pulse;
  int m_pulses;       // crossings since reset/clear

  function automatic int eff_speed();
`ifdef PIPE_SPEEDUP_EN
    int s;
    s = SPEED + m_pulses / 8;
    return (s > 2*SPEED) ? 2*SPEED : s;
`else
    return SPEED;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_cnt = SPACING;
    m_pulse = 0;
    m_pulses = 0;
    for (int i = 0; i < NP; i++) begin
      m_v[i] = 0;
      m_x[i] = 0;
      m_g[i] = 0;
    end
  endtask

  task automatic model_step();
    bit was_v[NP];
    int free;
    int spd;
    if (!rstn || clear) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    if (m_state == 1 && frame_tick) begin
      spd = eff_speed();
      free = -1;
      for (int i = 0; i < NP; i++) begin
        was_v[i] = m_v[i];
        if (!m_v[i] && free < 0) free = i;
      end
      for (int i = 0; i < NP; i++) begin
        if (was_v[i]) begin
          if (m_x[i] <= spd) m_v[i] = 0;
          else begin
            if (m_x[i] > BIRD_X && m_x[i] - spd <= BIRD_X) m_pulse = 1;
            m_x[i] = m_x[i] - spd;
          end
        end
      end
      m_cnt = (m_cnt + spd > SPACING) ? SPACING : m_cnt + spd;
      if (m_cnt >= SPACING && free >= 0) begin
        m_v[free] = 1;
        m_x[free] = SPAWN_X;
        m_g[free] = GAP_MIN + (int'(rand_num[15:0]) * GAP_RANGE) / 65536;
        m_cnt = 0;
      end
      if (m_pulse) m_pulses++;
    end
    case (m_state)
      0: if (run)  m_state = 1;
      1: if (!run) m_state = 2;
      default: if (run) m_state = 1;
    endcase
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [NP-1:0]    v;
    logic [NP*XW-1:0] xv;
    logic [NP*YW-1:0] gv;
    v = '0; xv = '0; gv = '0;
    for (int i = 0; i < NP; i++) begin
      v[i] = m_v[i];
      if (m_v[i]) begin
        xv[i*XW +: XW] = XW'(m_x[i]);
        gv[i*YW +: YW] = YW'(m_g[i]);
      end
    end
    return {2'(m_state), (m_state != 0), m_pulse, v, xv, gv};
  endfunction

  // Positions and gaps of empty slots are don't-care, so they are masked out.
  function automatic logic [W-1:0] pack_dut();
    logic [NP*XW-1:0] xv;
    logic [NP*YW-1:0] gv;
    xv = '0; gv = '0;
    for (int i = 0; i < NP; i++) begin
      if (pipe_valid[i]) begin
        xv[i*XW +: XW] = pipe_x[i*XW +: XW];
        gv[i*YW +: YW] = pipe_gap_y[i*YW +: YW];
      end
    end
    return {state_dbg, busy, score_pulse, pipe_valid, xv, gv};
  endfunction

  // Driver: apply one cycle of inputs and record the expected result.
  task automatic cycle(input bit t, input bit r, input bit c, input bit rs,
                       input logic [31:0] rn);
    @(negedge clk);
    frame_tick = t;
    run = r;
    clear = c;
    rstn = rs;
    rand_num = rn;
    model_step();
    exp_q.push_back(pack_model());
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = pack_dut();
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t actual=%h expected=%h", $time, a, e);
        end
      end
    end
  end

  initial begin
    bit r;
    bit c;
    bit rs;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);                  // IDLE -> RUN
    cycle(1, 1, 0, 1, 32'h0000_8000);      // first tick spawns
    @(posedge clk); #2;
    check("spawn_valid0", int'(pipe_valid[0]), 1);
    check("spawn_x0", int'(pipe_x[XW-1:0]), 692);
    check("spawn_gap0", int'(pipe_gap_y[YW-1:0]), 140);
    check("spawn_busy", int'(busy), 1);

    for (int k = 1; k <= 360; k++) begin
      cycle(1, 1, 0, 1, $urandom);
      @(posedge clk); #2;
      if (k == 119) check("slot1_not_yet", int'(pipe_valid[1]), 0);
      if (k == 120) check("slot1_spawn", int'(pipe_valid[1]), 1);
      if (k == 120) check("slot1_x", int'(pipe_x[2*XW-1:XW]), 692);
      if (k == 240) check("full_valid", int'(pipe_valid), 3);
      if (k == 240) check("scroll_x0_k240", int'(pipe_x[XW-1:0]), 212);
      if (k == 265) check("no_score_k265", int'(score_pulse), 0);
      if (k == 266) check("score_k266", int'(score_pulse), 1);
      if (k == 345) check("x0_k345", int'(pipe_x[XW-1:0]), 2);
      if (k == 346) check("retire_k346", int'(pipe_valid[0]), 0);
      if (k == 347) check("respawn_k347", int'(pipe_valid[0]), 1);
      if (k == 347) check("respawn_x_k347", int'(pipe_x[XW-1:0]), 692);
      cycle(0, 1, 0, 1, $urandom);
    end

    // Randomized play: pauses, clears and mid-run resets.
    r = 1;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 63) == 0) r = ~r;
      c  = ($urandom_range(0, 599) == 0);
      rs = ($urandom_range(0, 1999) != 0);
      cycle(bit'($urandom_range(0, 1)), r, c, rs, $urandom);
    end
    cycle(0, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
